// File: rtl/datapath_multicycle_if.sv
// Handshake/bus bundle between the control unit, data memory and the multicycle datapath.
interface datapath_multicycle_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instruction;
    logic             ALUSrc;
    logic             RegWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             ExtOp;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Overflow;
    logic             done;
    logic [4:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output instr_valid, instruction, ALUSrc, RegWrite, RegDst, MemtoReg, ExtOp,
               ALUControl, mem_data, dbg_addr,
        input  instr_ready, ALUResult, Zero, Overflow, done, dbg_data
    );

    modport slave (
        input  instr_valid, instruction, ALUSrc, RegWrite, RegDst, MemtoReg, ExtOp,
               ALUControl, mem_data, dbg_addr,
        output instr_ready, ALUResult, Zero, Overflow, done, dbg_data
    );
endinterface

// File: rtl/datapath_multicycle.sv
// Multicycle MIPS register/ALU datapath: IDLE -> DECODE -> EXEC -> WB per instruction,
// with a new instruction accepted either in IDLE or overlapping the WB cycle.
module datapath_multicycle #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input logic                  clk,
    input logic                  reset,
    datapath_multicycle_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;

    logic [1:0]       state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic             alusrc_q, alusrc_d, regwrite_q, regwrite_d;
    logic             regdst_q, regdst_d, memtoreg_q, memtoreg_d, extop_q, extop_d;
    logic [3:0]       aluctrl_q, aluctrl_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] regs_q [NUM_REGS];

    logic [IDX_W-1:0] rs_c, rt_c, rd_c, wb_idx_c;
    logic             ready_c, accept_c, wb_en_c, alu_ovf_c;
    logic [WIDTH-1:0] wb_data_c, imm_ext_c, op2_c, sum_c, diff_c, alu_res_c;
    logic [31:0]      shamt_c;
    logic             unused_bits_c;

    assign rs_c     = ir_q[21 +: IDX_W];
    assign rt_c     = ir_q[16 +: IDX_W];
    assign rd_c     = ir_q[11 +: IDX_W];
    assign ready_c  = (state_q == S_IDLE) || (state_q == S_WB);
    assign accept_c = ready_c && bus.instr_valid;

    // Writeback lands at the WB edge; an index aliasing to 0 is discarded like $0.
    assign wb_idx_c  = regdst_q ? rd_c : rt_c;
    assign wb_data_c = memtoreg_q ? bus.mem_data : result_q;
    assign wb_en_c   = (state_q == S_WB) && regwrite_q && (wb_idx_c != '0);

    // Immediate extension
    always_comb begin
        imm_ext_c = WIDTH'(ir_q[15:0]);
        for (int i = 16; i < WIDTH; i++) begin
            imm_ext_c[i] = extop_q & ir_q[15];
        end
    end

    // ALU
    always_comb begin
        op2_c     = alusrc_q ? imm_q : b_q;
        sum_c     = a_q + op2_c;
        diff_c    = a_q - op2_c;
        shamt_c   = 32'(ir_q[10:6]) % WIDTH;
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        case (aluctrl_q)
            OP_AND: alu_res_c = a_q & op2_c;
            OP_OR:  alu_res_c = a_q | op2_c;
            OP_ADD: begin
                alu_res_c = sum_c;
                alu_ovf_c = (a_q[WIDTH-1] == op2_c[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = (a_q[WIDTH-1] != op2_c[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SLT: alu_res_c = WIDTH'($signed(a_q) < $signed(op2_c));
            OP_NOR: alu_res_c = ~(a_q | op2_c);
            OP_SLL: alu_res_c = op2_c << shamt_c;
            OP_SRL: alu_res_c = op2_c >> shamt_c;
            default: begin
                alu_res_c = '0;
                alu_ovf_c = 1'b0;
            end
        endcase
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        alusrc_d   = alusrc_q;
        regwrite_d = regwrite_q;
        regdst_d   = regdst_q;
        memtoreg_d = memtoreg_q;
        extop_d    = extop_q;
        aluctrl_d  = aluctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        result_d   = result_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = regs_q[rs_c];
                b_d     = regs_q[rt_c];
                imm_d   = imm_ext_c;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_res_c;
                zero_d   = (alu_res_c == '0);
                ovf_d    = alu_ovf_c;
                state_d  = S_WB;
            end
            S_WB: begin
                state_d = accept_c ? S_DECODE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (accept_c) begin
            ir_d       = bus.instruction;
            alusrc_d   = bus.ALUSrc;
            regwrite_d = bus.RegWrite;
            regdst_d   = bus.RegDst;
            memtoreg_d = bus.MemtoReg;
            extop_d    = bus.ExtOp;
            aluctrl_d  = bus.ALUControl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            regdst_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            extop_q    <= 1'b0;
            aluctrl_q  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            regdst_q   <= regdst_d;
            memtoreg_q <= memtoreg_d;
            extop_q    <= extop_d;
            aluctrl_q  <= aluctrl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
        end
    end

    // Register file; reset takes priority so a reset during WB drops the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_en_c) begin
            regs_q[wb_idx_c] <= wb_data_c;
        end
    end

    assign bus.instr_ready = ready_c;
    assign bus.done        = (state_q == S_WB);
    assign bus.ALUResult   = result_q;
    assign bus.Zero        = zero_q;
    assign bus.Overflow    = ovf_q;
    assign bus.dbg_data    = regs_q[bus.dbg_addr[IDX_W-1:0]];

    // Opcode/funct and high index bits carry no meaning for this datapath.
    assign unused_bits_c = ^{ir_q, bus.dbg_addr};
endmodule

// File: tb/tb_datapath_multicycle.sv
// Directed bench for datapath_multicycle at WIDTH=32/NUM_REGS=32 and WIDTH=16/NUM_REGS=8.
module tb_datapath_multicycle;
    localparam logic [3:0] A_AND = 4'b0000, A_OR  = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111, A_NOR = 4'b1100, A_SLL = 4'b1000, A_SRL = 4'b1001;
    localparam logic [3:0] A_BAD = 4'b0011;
    // control word {ALUSrc, RegWrite, RegDst, MemtoReg, ExtOp, ALUControl}
    localparam logic [8:0] C_ADDI = {5'b11001, A_ADD};
    localparam logic [8:0] C_ORI  = {5'b11000, A_OR};
    localparam logic [8:0] C_LW   = {5'b11011, A_ADD};

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [63:0] res;
        logic        zero;
        logic        ovf;
    } exp_t;
    exp_t  sb[$];
    string tag_q[$];

    datapath_multicycle_if #(.WIDTH(32)) ifa ();
    datapath_multicycle_if #(.WIDTH(16)) ifb ();

    datapath_multicycle #(.WIDTH(32), .NUM_REGS(32)) u_a (.clk(clk), .reset(reset), .bus(ifa));
    datapath_multicycle #(.WIDTH(16), .NUM_REGS(8))  u_b (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [8:0] c_r(input logic [3:0] op);
        return {5'b01100, op};
    endfunction

    function automatic logic [31:0] i_t(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'h08, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_t(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, 6'h20};
    endfunction

    function automatic logic [63:0] res_of(input bit sel);
        return sel ? 64'(ifb.ALUResult) : 64'(ifa.ALUResult);
    endfunction

    // {instr_ready, done, Zero, Overflow}
    function automatic logic [3:0] flags(input bit sel);
        return sel ? {ifb.instr_ready, ifb.done, ifb.Zero, ifb.Overflow}
                   : {ifa.instr_ready, ifa.done, ifa.Zero, ifa.Overflow};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [31:0] ins,
                         input logic [8:0] c, input logic [63:0] mem);
        if (sel) begin
            ifb.instr_valid = v;
            ifb.instruction = ins;
            {ifb.ALUSrc, ifb.RegWrite, ifb.RegDst, ifb.MemtoReg, ifb.ExtOp, ifb.ALUControl} = c;
            ifb.mem_data = mem[15:0];
        end else begin
            ifa.instr_valid = v;
            ifa.instruction = ins;
            {ifa.ALUSrc, ifa.RegWrite, ifa.RegDst, ifa.MemtoReg, ifa.ExtOp, ifa.ALUControl} = c;
            ifa.mem_data = mem[31:0];
        end
    endtask

    task automatic expect_res(input logic [63:0] res, input logic z, input logic o, input string tag);
        sb.push_back('{res: res, zero: z, ovf: o});
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input bit sel);
        exp_t  e;
        string t;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard: observed empty queue expected pending entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            t = tag_q.pop_front();
            check({t, ".res"}, res_of(sel), e.res);
            check({t, ".flags"}, 64'(flags(sel)), 64'({2'b11, e.zero, e.ovf}));
        end
    endtask

    // Waits (bounded) for done after an accept edge; done must appear in the third cycle.
    task automatic complete(input bit sel);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!flags(sel)[2] && lat < 8);
        check("latency", 64'(lat), 64'd3);
        pop_check(sel);
    endtask

    task automatic run(input bit sel, input logic [31:0] ins, input logic [8:0] c, input logic [63:0] mem,
                       input logic [63:0] res, input logic z, input logic o, input string tag);
        expect_res(res, z, o, tag);
        drive(sel, 1'b1, ins, c, mem);
        @(posedge clk); #1;
        drive(sel, 1'b0, ins, c, mem);
        complete(sel);
        @(posedge clk); #1;
    endtask

    task automatic dbg(input bit sel, input logic [4:0] addr, input logic [63:0] exp, input string tag);
        if (sel) ifb.dbg_addr = addr;
        else     ifa.dbg_addr = addr;
        #1;
        check(tag, sel ? 64'(ifb.dbg_data) : 64'(ifa.dbg_data), exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 9'd0, 64'd0);
        drive(1'b1, 1'b0, 32'd0, 9'd0, 64'd0);
        ifa.dbg_addr = 5'd0;
        ifb.dbg_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("a.rst.res", res_of(1'b0), 64'd0);
        check("a.rst.flags", 64'(flags(1'b0)), 64'b1000);
        check("b.rst.flags", 64'(flags(1'b1)), 64'b1000);

        // ---------------- WIDTH=32, NUM_REGS=32 ----------------
        run(0, i_t(5'd0, 5'd1, 16'd5), C_ADDI, 64'd0, 64'd5, 1'b0, 1'b0, "a.addi1");
        run(0, i_t(5'd0, 5'd2, 16'd7), C_ADDI, 64'd0, 64'd7, 1'b0, 1'b0, "a.addi2");
        run(0, r_t(5'd1, 5'd2, 5'd3, 5'd0), c_r(A_ADD), 64'd0, 64'd12, 1'b0, 1'b0, "a.add3");
        dbg(0, 5'd3, 64'd12, "a.dbg3");
        run(0, r_t(5'd1, 5'd1, 5'd4, 5'd0), c_r(A_SUB), 64'd0, 64'd0, 1'b1, 1'b0, "a.sub4");
        run(0, i_t(5'd0, 5'd8, 16'd0), C_LW, 64'h7FFF_FFFF, 64'd0, 1'b1, 1'b0, "a.lw8");
        dbg(0, 5'd8, 64'h7FFF_FFFF, "a.dbg8");
        run(0, i_t(5'd0, 5'd9, 16'd1), C_ADDI, 64'd0, 64'd1, 1'b0, 1'b0, "a.addi9");
        run(0, r_t(5'd8, 5'd9, 5'd10, 5'd0), c_r(A_ADD), 64'd0, 64'h8000_0000, 1'b0, 1'b1, "a.addovf");
        run(0, r_t(5'd10, 5'd9, 5'd13, 5'd0), c_r(A_SUB), 64'd0, 64'h7FFF_FFFF, 1'b0, 1'b1, "a.subovf");
        run(0, i_t(5'd1, 5'd11, 16'd4), C_LW, 64'hDEAD_BEEF, 64'd9, 1'b0, 1'b0, "a.lw11");
        dbg(0, 5'd11, 64'hDEAD_BEEF, "a.dbg11");
        run(0, i_t(5'd0, 5'd5, 16'hFFFF), C_ORI, 64'd0, 64'h0000_FFFF, 1'b0, 1'b0, "a.ori5");
        run(0, i_t(5'd0, 5'd6, 16'hFFFF), C_ADDI, 64'd0, 64'hFFFF_FFFF, 1'b0, 1'b0, "a.addi6");
        run(0, r_t(5'd6, 5'd0, 5'd7, 5'd0), c_r(A_SLT), 64'd0, 64'd1, 1'b0, 1'b0, "a.slt7");
        dbg(0, 5'd7, 64'd1, "a.dbg7");
        run(0, r_t(5'd0, 5'd6, 5'd14, 5'd0), c_r(A_SLT), 64'd0, 64'd0, 1'b1, 1'b0, "a.slt14");
        run(0, r_t(5'd0, 5'd9, 5'd12, 5'd4), c_r(A_SLL), 64'd0, 64'h10, 1'b0, 1'b0, "a.sll");
        run(0, r_t(5'd0, 5'd6, 5'd15, 5'd8), c_r(A_SRL), 64'd0, 64'h00FF_FFFF, 1'b0, 1'b0, "a.srl");
        run(0, r_t(5'd0, 5'd0, 5'd16, 5'd0), c_r(A_NOR), 64'd0, 64'hFFFF_FFFF, 1'b0, 1'b0, "a.nor");
        run(0, r_t(5'd5, 5'd6, 5'd17, 5'd0), c_r(A_AND), 64'd0, 64'h0000_FFFF, 1'b0, 1'b0, "a.and");
        run(0, r_t(5'd1, 5'd1, 5'd0, 5'd0), c_r(A_ADD), 64'd0, 64'd10, 1'b0, 1'b0, "a.add0");
        dbg(0, 5'd0, 64'd0, "a.dbg0");

        // Back-to-back: second instruction accepted in the WB cycle of the first.
        expect_res(64'd3, 1'b0, 1'b0, "a.b2b.addi");
        expect_res(64'd6, 1'b0, 1'b0, "a.b2b.add");
        drive(0, 1'b1, i_t(5'd0, 5'd1, 16'd3), C_ADDI, 64'd0);
        @(negedge clk); check("a.b2b.rdy_idle", 64'(flags(1'b0)[3]), 64'd1);
        @(posedge clk); #1;
        drive(0, 1'b1, r_t(5'd1, 5'd1, 5'd2, 5'd0), c_r(A_ADD), 64'd0);
        @(negedge clk); check("a.b2b.rdy_dec", 64'(flags(1'b0)[3]), 64'd0);
        @(negedge clk); check("a.b2b.rdy_exe", 64'(flags(1'b0)[3]), 64'd0);
        @(negedge clk); pop_check(1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 9'd0, 64'd0);
        complete(1'b0);
        @(posedge clk); #1;
        dbg(0, 5'd1, 64'd3, "a.b2b.dbg1");
        dbg(0, 5'd2, 64'd6, "a.b2b.dbg2");
        run(0, r_t(5'd1, 5'd2, 5'd18, 5'd0), c_r(A_BAD), 64'd0, 64'd0, 1'b1, 1'b0, "a.badop");

        // Reset during WB discards the pending write and clears everything.
        do_reset();
        run(0, i_t(5'd0, 5'd1, 16'd5), C_ADDI, 64'd0, 64'd5, 1'b0, 1'b0, "a.r.addi1");
        run(0, i_t(5'd0, 5'd2, 16'd7), C_ADDI, 64'd0, 64'd7, 1'b0, 1'b0, "a.r.addi2");
        expect_res(64'd12, 1'b0, 1'b0, "a.r.add3");
        drive(0, 1'b1, r_t(5'd1, 5'd2, 5'd3, 5'd0), c_r(A_ADD), 64'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 9'd0, 64'd0);
        complete(1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("a.rwb.res", res_of(1'b0), 64'd0);
        check("a.rwb.flags", 64'(flags(1'b0)), 64'b1000);
        dbg(0, 5'd3, 64'd0, "a.rwb.dbg3");
        dbg(0, 5'd1, 64'd0, "a.rwb.dbg1");

        // ---------------- WIDTH=16, NUM_REGS=8 ----------------
        do_reset();
        run(1, i_t(5'd0, 5'd1, 16'd5), C_ADDI, 64'd0, 64'd5, 1'b0, 1'b0, "b.addi1");
        run(1, i_t(5'd0, 5'd2, 16'd7), C_ADDI, 64'd0, 64'd7, 1'b0, 1'b0, "b.addi2");
        run(1, r_t(5'd1, 5'd2, 5'd3, 5'd0), c_r(A_ADD), 64'd0, 64'd12, 1'b0, 1'b0, "b.add3");
        dbg(1, 5'd3, 64'd12, "b.dbg3");
        run(1, r_t(5'd1, 5'd1, 5'd4, 5'd0), c_r(A_SUB), 64'd0, 64'd0, 1'b1, 1'b0, "b.sub4");
        run(1, i_t(5'd0, 5'd9, 16'h7FFF), C_ADDI, 64'd0, 64'h7FFF, 1'b0, 1'b0, "b.addi9");
        dbg(1, 5'd1, 64'h7FFF, "b.alias1");
        dbg(1, 5'd9, 64'h7FFF, "b.alias9");
        run(1, i_t(5'd0, 5'd5, 16'd1), C_ADDI, 64'd0, 64'd1, 1'b0, 1'b0, "b.addi5");
        run(1, r_t(5'd1, 5'd5, 5'd6, 5'd0), c_r(A_ADD), 64'd0, 64'h8000, 1'b0, 1'b1, "b.addovf");
        run(1, r_t(5'd6, 5'd6, 5'd7, 5'd0), c_r(A_ADD), 64'd0, 64'h0000, 1'b1, 1'b1, "b.wrap");
        run(1, i_t(5'd0, 5'd6, 16'hFFFF), C_ADDI, 64'd0, 64'hFFFF, 1'b0, 1'b0, "b.addi6");
        run(1, r_t(5'd0, 5'd5, 5'd7, 5'd20), c_r(A_SLL), 64'd0, 64'h10, 1'b0, 1'b0, "b.sllmod");
        dbg(1, 5'd15, 64'h10, "b.alias15");

        check("scoreboard.drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
